// File: rtl/cdp1802_loader.sv
`default_nettype none
// ============================================================================
// Module   : cdp1802_loader
// Purpose  : Boot sequencer and RAM-port owner for the cdp1802 core.
//            Holds the CPU in reset while a host streams a big-endian header
//            (load address, byte count) followed by program bytes over a
//            valid/ready byte channel. Each byte is written to the shared RAM.
//            A fixed hold interval follows, and then the CPU is released.
//            Once the CPU runs, the RAM port passes straight through to it.
//            A reload pulse in any state returns the block to load mode.
// Ports    : clock, reset          - clock / async active-high reset
//            in_data/in_valid/in_ready - host byte stream
//            reload                - restart load sequence, halt CPU
//            cpu_resetq, running   - CPU reset (active low) / CPU owns RAM
//            cpu_ram_*             - CPU side of the RAM port
//            mem_*                 - physical RAM port
// Revision : 1.0 - initial release
// ============================================================================
module cdp1802_loader #(
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  output logic        cpu_resetq,
  output logic        running,
  input  logic        cpu_ram_rd,
  input  logic        cpu_ram_wr,
  input  logic [15:0] cpu_ram_a,
  input  logic [7:0]  cpu_ram_d,
  output logic [7:0]  cpu_ram_q,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_d,
  input  logic [7:0]  mem_q
);

  // The hold counter counts down to zero inclusive, so it starts one short.
  localparam logic [7:0] c_HOLD_INIT = 8'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_ADDR_HI = 3'd0,
    S_ADDR_LO = 3'd1,
    S_LEN_HI  = 3'd2,
    S_LEN_LO  = 3'd3,
    S_DATA    = 3'd4,
    S_HOLD    = 3'd5,
    S_RUN     = 3'd6
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_addr,  w_addr_nxt;
  logic [15:0] r_len,   w_len_nxt;
  logic [7:0]  r_cnt,   w_cnt_nxt;
  logic        r_cpu_resetq, w_cpu_resetq_nxt;

  logic w_loading;
  logic w_accept;

  // Byte channel is open in the header and data states, but a reload in the
  // same cycle wins so that an aborted load never writes another byte.
  assign w_loading = (r_state == S_ADDR_HI) || (r_state == S_ADDR_LO) ||
                     (r_state == S_LEN_HI)  || (r_state == S_LEN_LO)  ||
                     (r_state == S_DATA);
  assign in_ready  = w_loading & ~reload;
  assign w_accept  = in_valid & in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_ADDR_HI;
      r_addr       <= 16'h0000;
      r_len        <= 16'h0000;
      r_cnt        <= 8'h00;
      r_cpu_resetq <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_len        <= w_len_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cpu_resetq <= w_cpu_resetq_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_len_nxt        = r_len;
    w_cnt_nxt        = r_cnt;
    w_cpu_resetq_nxt = r_cpu_resetq;

    if (reload) begin
      // addr/len/counter deliberately keep their values.
      w_state_nxt      = S_ADDR_HI;
      w_cpu_resetq_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR_HI: if (w_accept) begin
          w_addr_nxt[15:8] = in_data;
          w_state_nxt      = S_ADDR_LO;
        end
        S_ADDR_LO: if (w_accept) begin
          w_addr_nxt[7:0] = in_data;
          w_state_nxt     = S_LEN_HI;
        end
        S_LEN_HI: if (w_accept) begin
          w_len_nxt[15:8] = in_data;
          w_state_nxt     = S_LEN_LO;
        end
        S_LEN_LO: if (w_accept) begin
          w_len_nxt[7:0] = in_data;
          // An empty program skips straight to the hold interval.
          if ({r_len[15:8], in_data} == 16'h0000) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = c_HOLD_INIT;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: if (w_accept) begin
          w_addr_nxt = r_addr + 16'h0001;
          w_len_nxt  = r_len - 16'h0001;
          if (r_len == 16'h0001) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = c_HOLD_INIT;
          end
        end
        S_HOLD: begin
          if (r_cnt == 8'h00) begin
            w_state_nxt      = S_RUN;
            w_cpu_resetq_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 8'h01;
          end
        end
        S_RUN: begin
          w_state_nxt = S_RUN;
        end
        default: begin
          w_state_nxt = S_ADDR_HI;
        end
      endcase
    end
  end

  // RAM port mux: the loader owns RAM until RUN, then the CPU does.
  always_comb begin
    mem_rd = 1'b0;
    mem_wr = w_accept & (r_state == S_DATA);
    mem_a  = r_addr;
    mem_d  = in_data;
    if (r_state == S_RUN) begin
      mem_rd = cpu_ram_rd;
      mem_wr = cpu_ram_wr;
      mem_a  = cpu_ram_a;
      mem_d  = cpu_ram_d;
    end
  end

  assign cpu_ram_q  = mem_q;
  assign running    = (r_state == S_RUN);
  assign cpu_resetq = r_cpu_resetq;

endmodule
`default_nettype wire

// File: tb/tb_cdp1802_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdp1802_loader
// Purpose  : Self-checking bench for cdp1802_loader. A phase-level reference
//            model (header byte index, remaining length, hold countdown) is
//            stepped alongside the DUT and every visible output is compared
//            each cycle, under directed streams and randomized loads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdp1802_loader;

  localparam int c_RELEASE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        cpu_resetq;
  logic        running;
  logic        cpu_ram_rd;
  logic        cpu_ram_wr;
  logic [15:0] cpu_ram_a;
  logic [7:0]  cpu_ram_d;
  logic [7:0]  cpu_ram_q;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_a;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q;

  cdp1802_loader #(.RELEASE_CYCLES(c_RELEASE)) u_dut (
    .clock      (clk),
    .reset      (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload     (reload),
    .cpu_resetq (cpu_resetq),
    .running    (running),
    .cpu_ram_rd (cpu_ram_rd),
    .cpu_ram_wr (cpu_ram_wr),
    .cpu_ram_a  (cpu_ram_a),
    .cpu_ram_d  (cpu_ram_d),
    .cpu_ram_q  (cpu_ram_q),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_a      (mem_a),
    .mem_d      (mem_d),
    .mem_q      (mem_q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 header, 1 data, 2 hold, 3 run
  int          m_phase;
  int          m_hdr;
  logic [15:0] m_addr;
  logic [15:0] m_len;
  int          m_hold;
  logic        m_resetq;
  int          n_writes;

  task automatic model_reset();
    m_phase  = 0;
    m_hdr    = 0;
    m_addr   = 16'h0000;
    m_len    = 16'h0000;
    m_hold   = 0;
    m_resetq = 1'b0;
  endtask

  // Check all outputs against the model for the current inputs.
  task automatic check_outputs(output bit acc);
    bit exp_ready;
    exp_ready = (m_phase < 2) && !reload;
    acc       = in_valid && exp_ready;
    check("in_ready",   in_ready,   exp_ready);
    check("running",    running,    m_phase == 3);
    check("cpu_resetq", cpu_resetq, m_resetq);
    check("cpu_ram_q",  cpu_ram_q,  mem_q);
    if (m_phase == 3) begin
      check("run_mem_rd", mem_rd, cpu_ram_rd);
      check("run_mem_wr", mem_wr, cpu_ram_wr);
      check("run_mem_a",  mem_a,  cpu_ram_a);
      check("run_mem_d",  mem_d,  cpu_ram_d);
    end else begin
      check("mem_rd", mem_rd, 1'b0);
      check("mem_wr", mem_wr, acc && (m_phase == 1));
      check("mem_a",  mem_a,  m_addr);
      check("mem_d",  mem_d,  in_data);
    end
    if (acc && m_phase == 1) n_writes++;
  endtask

  task automatic model_step(input bit acc);
    if (reload) begin
      m_phase  = 0;
      m_hdr    = 0;
      m_resetq = 1'b0;
    end else if (m_phase == 0 && acc) begin
      case (m_hdr)
        0: m_addr[15:8] = in_data;
        1: m_addr[7:0]  = in_data;
        2: m_len[15:8]  = in_data;
        default: m_len[7:0] = in_data;
      endcase
      if (m_hdr == 3) begin
        m_hdr = 0;
        if (m_len == 0) begin m_phase = 2; m_hold = c_RELEASE; end
        else m_phase = 1;
      end else begin
        m_hdr++;
      end
    end else if (m_phase == 1 && acc) begin
      m_addr = m_addr + 16'd1;
      m_len  = m_len - 16'd1;
      if (m_len == 0) begin m_phase = 2; m_hold = c_RELEASE; end
    end else if (m_phase == 2) begin
      m_hold--;
      if (m_hold == 0) begin m_phase = 3; m_resetq = 1'b1; end
    end
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+4, then clock edge.
  task automatic cycle_full(input bit v, input logic [7:0] d, input bit rl,
                            input bit crd, input bit cwr, input logic [15:0] ca,
                            input logic [7:0] cd, input logic [7:0] q, output bit acc);
    in_valid   = v;
    in_data    = d;
    reload     = rl;
    cpu_ram_rd = crd;
    cpu_ram_wr = cwr;
    cpu_ram_a  = ca;
    cpu_ram_d  = cd;
    mem_q      = q;
    #3;
    check_outputs(acc);
    @(posedge clk);
    model_step(acc);
    #1;
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit rl, output bit acc);
    cycle_full(v, d, rl, 1'($urandom), 1'($urandom), 16'($urandom),
               8'($urandom), 8'($urandom), acc);
  endtask

  task automatic do_reset();
    bit dummy;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_in_ready",   in_ready,   1'b1);
    check("rst_running",    running,    1'b0);
    check("rst_cpu_resetq", cpu_resetq, 1'b0);
    check("rst_mem_wr",     mem_wr,     1'b0);
    check("rst_mem_rd",     mem_rd,     1'b0);
    check("rst_mem_a",      mem_a,      16'h0000);
    check("rst_mem_d",      mem_d,      8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, dummy);
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input bit gaps);
    bit acc;
    int i, budget;
    i = 0;
    budget = 0;
    while (i < bytes.size() && budget < 100) begin
      cyc(gaps ? !budget[0] : 1'b1, bytes[i], 1'b0, acc);
      if (acc) i++;
      budget++;
    end
    check("stream_done", i, bytes.size());
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) cyc(1'b0, 8'($urandom), 1'b0, acc);
  endtask

  initial begin
    logic [7:0] s[$];
    bit acc;
    int w0;
    rst = 1'b0;
    in_valid = 0; in_data = 0; reload = 0;
    cpu_ram_rd = 0; cpu_ram_wr = 0; cpu_ram_a = 0; cpu_ram_d = 0; mem_q = 0;
    model_reset();
    n_writes = 0;
    #1;
    do_reset();

    // Basic load with in_valid held high.
    w0 = n_writes;
    s = '{8'h01, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_stream(s, 1'b0);
    check("basic_writes", n_writes - w0, 3);
    idle(c_RELEASE + 2);
    check("basic_running", running, 1'b1);

    // Pass-through in RUN.
    cycle_full(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0100, 8'h00, 8'hAA, acc);
    cycle_full(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0200, 8'h55, 8'h00, acc);

    // Reload while running, then backpressure load.
    cyc(1'b0, 8'h00, 1'b1, acc);
    check("reload_run_drop", running, 1'b0);
    w0 = n_writes;
    send_stream(s, 1'b1);
    check("gap_writes", n_writes - w0, 3);
    idle(c_RELEASE + 2);

    // Zero length.
    cyc(1'b0, 8'h00, 1'b1, acc);
    w0 = n_writes;
    s = '{8'h12, 8'h34, 8'h00, 8'h00};
    send_stream(s, 1'b0);
    idle(c_RELEASE + 2);
    check("zero_writes", n_writes - w0, 0);

    // Address wrap.
    cyc(1'b0, 8'h00, 1'b1, acc);
    s = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22};
    send_stream(s, 1'b0);
    idle(c_RELEASE + 2);

    // Reload mid-DATA with a simultaneous byte.
    cyc(1'b0, 8'h00, 1'b1, acc);
    w0 = n_writes;
    s = '{8'h01, 8'h00, 8'h00, 8'h04, 8'hAA};
    send_stream(s, 1'b0);
    cyc(1'b1, 8'hBB, 1'b1, acc);
    check("reload_blocks", acc, 1'b0);
    check("reload_writes", n_writes - w0, 1);
    s = '{8'h03, 8'h00, 8'h00, 8'h01, 8'h77};
    send_stream(s, 1'b0);
    idle(c_RELEASE + 2);

    // Randomized loads with random gaps and occasional reloads.
    for (int it = 0; it < 40; it++) begin
      logic [7:0] q[$];
      int len, runc;
      if (it == 20) do_reset();
      cyc(1'b0, 8'h00, 1'b1, acc);
      len = $urandom_range(0, 6);
      q = '{};
      q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      q.push_back(8'($urandom));
      q.push_back(8'h00);
      q.push_back(8'(len));
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      runc = 0;
      for (int c = 0; c < 200 && runc < 6; c++) begin
        bit v, rl;
        v  = ($urandom_range(0, 3) != 0) && (q.size() > 0);
        rl = ($urandom_range(0, 59) == 0);
        cyc(v, (q.size() > 0) ? q[0] : 8'($urandom), rl, acc);
        if (acc) void'(q.pop_front());
        if (rl) begin
          q = '{8'($urandom), 8'($urandom), 8'h00, 8'($urandom_range(0, 4))};
          for (int k = 0; k < int'(q[3]); k++) q.push_back(8'($urandom));
        end
        if (running) runc++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdp1802_loader.md
Name: cdp1802_loader

Overview:
- Boot sequencer and RAM-port owner for the cdp1802 core.
- Holds the CPU in reset while a host streams a header and program bytes over a valid/ready byte channel. Writes the bytes into the shared RAM, then releases the CPU.
- After release, the RAM port passes straight through to the CPU. A reload pulse at any time returns the system to load mode.

Parameters:
- RELEASE_CYCLES, 4: cycles cpu_resetq stays low after the last data byte before the CPU is released; legal range 1..255.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_data  in  8  host byte stream data
- in_valid  in  1  host byte present
- in_ready  out  1  loader accepts a byte this cycle
- reload  in  1  pulse: halt the CPU and restart the load sequence
- cpu_resetq  out  1  active-low reset to the cdp1802
- running  out  1  high while the CPU owns RAM (state RUN)
- cpu_ram_rd  in  1  CPU RAM read enable
- cpu_ram_wr  in  1  CPU RAM write enable
- cpu_ram_a  in  16  CPU RAM address
- cpu_ram_d  in  8  CPU RAM write data
- cpu_ram_q  out  8  RAM read data returned to the CPU
- mem_rd  out  1  RAM read enable
- mem_wr  out  1  RAM write enable
- mem_a  out  16  RAM address
- mem_d  out  8  RAM write data
- mem_q  in  8  RAM read data

Behaviour:
- States, in order: ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, HOLD, RUN.
- Registers: addr[15:0], len[15:0], hold counter[7:0], cpu_resetq.
- Reset, asynchronous: state=ADDR_HI, addr=0, len=0, counter=0, cpu_resetq=0.
- Outputs during and just after reset: in_ready=1 (unless reload), running=0, mem_rd=0, mem_wr=0, mem_a=0, mem_d=0.
- Accept: a byte is accepted on a rising edge when in_valid & in_ready.
  - in_ready = (state in ADDR_HI..DATA) & ~reload; purely combinational.
  - The host may hold in_valid for any number of cycles; no byte is lost or duplicated.
- Header, big-endian, one accepted byte per state:
  - ADDR_HI: addr[15:8]=in_data → ADDR_LO.
  - ADDR_LO: addr[7:0]=in_data → LEN_HI.
  - LEN_HI: len[15:8]=in_data → LEN_LO.
  - LEN_LO: len[7:0]=in_data. If {len[15:8], in_data}==0 → HOLD, else → DATA.
- DATA write path:
  - mem_wr = in_valid & in_ready; mem_a = addr; mem_d = in_data; mem_rd = 0. The write is combinational in the accept cycle, so one byte per clock is sustained.
  - On accept: addr=addr+1, wrapping FFFF→0000; len=len-1.
  - Accepting the byte with len==1 → HOLD.
- HOLD:
  - On entry, counter loads RELEASE_CYCLES-1.
  - Counter decrements each cycle; when counter==0 → RUN and cpu_resetq=1 on the same edge.
  - cpu_resetq is therefore low for exactly RELEASE_CYCLES cycles in HOLD.
- RAM ownership:
  - Outside RUN: mem_rd=0; mem_wr only as in DATA; mem_a=addr; mem_d=in_data. CPU requests are ignored.
  - In RUN: mem_rd=cpu_ram_rd, mem_wr=cpu_ram_wr, mem_a=cpu_ram_a, mem_d=cpu_ram_d, all combinational pass-through. running=1; in_ready=0.
  - cpu_ram_q = mem_q in all states.
- reload:
  - Sampled on a rising edge in any state: → ADDR_HI and cpu_resetq=0 on that edge.
  - addr, len and counter are not cleared.
  - Bytes already written by an aborted load remain in RAM.
  - reload overrides a simultaneous in_valid: in_ready is forced to 0, so no byte is accepted and mem_wr=0 in that cycle.
- No other event releases the CPU. Once running, only reset or reload stops it.

Test Plan:
- Basic load: reset, then stream 01 00 00 03 AA BB CC with in_valid held high.
  - Required: in_ready=1 for 7 consecutive cycles; mem_wr pulses at 0x0100/AA, 0x0101/BB, 0x0102/CC.
  - Then cpu_resetq=0 for 4 cycles, then cpu_resetq=1 and running=1.
- Backpressure/gaps: same stream with in_valid toggling 1,0,1,0.
  - Required: exactly three writes with the same address/data pairs; no duplicates.
- Zero length: stream 12 34 00 00.
  - Required: no mem_wr; cpu_resetq rises exactly RELEASE_CYCLES cycles after the LEN_LO accept.
- Address wrap: header FF FF 00 02, then 11 22.
  - Required: writes 0xFFFF/11, then 0x0000/22.
- Pass-through: in RUN, drive cpu_ram_rd=1, cpu_ram_a=0x0100 with mem_q=AA.
  - Required: mem_rd=1, mem_a=0x0100, cpu_ram_q=AA in the same cycle.
  - Required: cpu_ram_wr=1 with cpu_ram_d=55 appears on mem_wr/mem_d.
- Reload mid-DATA: after 01 00 00 04 AA, assert reload together with in_valid and byte BB.
  - Required: BB not written; cpu_resetq=0; state back to ADDR_HI, so the next accepted byte is treated as ADDR_HI.
  - Required: reload while in RUN drops cpu_resetq and running on the next edge.
